dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Sequencer for one DSP48E2 MAC slice wrapper. It computes dot products of length `len`: sum over i of A[i]·B[i]. It accepts operand beats over a valid/ready stream and drives the slice's clock enable, OPMODE, INMODE and ALUMODE. Control words are aligned to the slice's pipeline depth, so the first product clears the accumulator and later products accumulate. The block sits beside the DSP wrapper in a TPU processing element. The operand datapath routes A/B to the slice directly; this block only supplies `op_zero` to force B=0.

## Interface
Parameters:
- `INPUTREG`, 1: A/B/C/D register depth of the controlled slice (0 or 1).
- `DSPPIPEREG`, 1: M/AD register depth of the slice (0 or 1).
- `OUTPUTREG`, 1: P register depth of the slice. Must be 1, since the accumulator needs it.
- `CONTROLREG`, 1: OPMODE/INMODE/ALUMODE register depth of the slice (0 or 1).
- `LEN_W`, 16: width of the length field.

Ports:
- `clk`, in, 1: single clock. The block has one clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset. The same net resets the slice.
- `start`, in, 1: job request. Sampled only in IDLE.
- `len`, in, LEN_W: number of beats, sampled with `start`.
- `busy`, out, 1: high from the cycle after start acceptance until the return to IDLE.
- `done`, out, 1: one-cycle pulse. Slice P holds the final sum.
- `in_valid`, in, 1: an operand beat is present on the datapath.
- `in_ready`, out, 1: the block accepts the beat.
- `op_zero`, out, 1: datapath forces B=0 into the slice.
- `dsp_enable`, out, 1: CE for all slice registers.
- `dsp_opmode`, out, 9: slice OPMODE.
- `dsp_inmode`, out, 5: slice INMODE.
- `dsp_alumode`, out, 4: slice ALUMODE.

## Operation
- Derived constants:
  - D = INPUTREG + DSPPIPEREG − CONTROLREG, the control delay in enabled cycles (0..2).
  - L = INPUTREG + DSPPIPEREG + OUTPUTREG, the beat-to-P depth.
- States:
  - IDLE → RUN on `start` && `len`≠0. `len` is loaded into the beat counter.
  - IDLE → ZERO on `start` && `len`==0.
  - RUN → DRAIN on acceptance of the final beat.
  - ZERO → DRAIN after 1 cycle.
  - DRAIN → IDLE after L−1 cycles.
- `in_ready` = (state==RUN). A beat is accepted when `in_valid` && `in_ready`.
- `dsp_enable` is combinational:
  - RUN: equals `in_valid`. A stall freezes the whole slice pipeline, including the partial sum.
  - ZERO and DRAIN: 1.
  - IDLE: 0, so P holds its value.
- `op_zero` = 1 in ZERO and DRAIN, 0 otherwise.
- A first flag marks beat 0 of RUN and the single ZERO beat. All other beats and drain slots carry 0.
  - The flag passes through a D-stage delay line that shifts only when `dsp_enable`=1.
  - D=0 means the flag passes straight through.
- `dsp_opmode` = OPM_CLEAR (9'b00_000_01_01, P = M) when the delayed flag is 1. Otherwise it is OPM_ACC (9'b00_010_01_01, P = P + M).
- `dsp_inmode` is constant 5'b00000: A·B with the D port disabled.
- `dsp_alumode` is constant 4'b0000.
- Drain slots multiply by zero with OPM_ACC, so P is unchanged by them.
- `len`==0 produces P=0 through the ZERO beat.
- Products are signed. Width and overflow follow the slice's 48-bit P; the block has no saturation.
- `start` while `busy` is ignored.
- `in_valid` in IDLE, ZERO or DRAIN is ignored (`in_ready`=0).

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `in_ready`=0, `dsp_enable`=0, `op_zero`=0.
  - `dsp_opmode`=OPM_ACC.
  - Delay line cleared.
- Reset mid-job aborts with no `done`. The slice P is cleared by the same `rst`.
- `start` accepted in cycle 0 puts RUN in cycle 1.
- With `in_valid` held high, beats are accepted in cycles 1..len.
- DRAIN occupies cycles len+1..len+L−1.
- `done` is high in cycle len+L, the first IDLE cycle. P is final in that cycle and stays stable until the next job's first enabled edge.
- Each stall cycle (RUN, `in_valid`=0) delays `done` by exactly 1.
- `start` in the `done` cycle is accepted. `done` and the new job's `busy` rise coexist.

## Structure
- Shared package `dsp_ctrl_pkg` contains:
  - OPM_CLEAR, OPM_ACC, INMODE_MUL, ALUMODE_ADD;
  - the state enum (IDLE, RUN, ZERO, DRAIN).
- Sub-module `ctrl_delay_line` is a parameterised depth-D, enable-gated shift register with synchronous reset. The OPMODE alignment uses it, and other DSP controllers reuse it.
- The bench instantiates this block with the DSP wrapper using default parameters.

## Test plan
- `len`=4, A={1,2,3,4}, B={5,6,7,8}, continuous valid, start at cycle 0: beats accepted in cycles 1–4, `done` at cycle 7, P=70.
- Same job with `in_valid` low in cycles 2–4: P unchanged during the stall, `done` at cycle 10, P=70.
- Back-to-back jobs, second job `len`=1, A=−2, B=3, started in the first job's `done` cycle: second `done` shows P=−6, with no carry-over of 70.
- `len`=0: ZERO in cycle 1, `done` at cycle 4, P=0, `in_ready` never high.
- `rst` in cycle 3 of a `len`=8 job: next cycle `busy`=0, `in_ready`=0, `dsp_enable`=0, no `done`, P=0.
- `start` pulsed in cycle 2 of a `len`=4 job: ignored, single `done` at cycle 7, P correct.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared constants and types for DSP48E2 slice controllers.
// OPMODE/INMODE/ALUMODE encodings plus the MAC sequencer state enum.
package dsp_ctrl_pkg;

  localparam logic [8:0] OPM_CLEAR   = 9'b00_000_01_01;
  localparam logic [8:0] OPM_ACC     = 9'b00_010_01_01;
  localparam logic [4:0] INMODE_MUL  = 5'b00000;
  localparam logic [3:0] ALUMODE_ADD = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ZERO  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Enabled-cycle gap between a beat entering the slice and its control word.
  function automatic int ctrl_delay(input int inputreg, input int dsppipereg,
                                    input int controlreg);
    return inputreg + dsppipereg - controlreg;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Enable-gated shift register used to align control words with a DSP pipeline.
// DEPTH=0 degenerates to a plain wire.
module ctrl_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, enable};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      // Stages only advance on slice-enabled cycles so stalls keep alignment.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (enable) begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Control sequencer for a DSP48E2 MAC slice computing dot products of length len.
// Drives CE/OPMODE so the first product clears P and later products accumulate.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int INPUTREG   = 1,
  parameter int DSPPIPEREG = 1,
  parameter int OUTPUTREG  = 1,
  parameter int CONTROLREG = 1,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             op_zero,
  output logic             dsp_enable,
  output logic [8:0]       dsp_opmode,
  output logic [4:0]       dsp_inmode,
  output logic [3:0]       dsp_alumode
);

  localparam int D = ctrl_delay(INPUTREG, DSPPIPEREG, CONTROLREG);
  localparam int L = INPUTREG + DSPPIPEREG + OUTPUTREG;
  localparam logic [1:0] DRAIN_LEN = 2'(L - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  seq_state_t       state;
  logic [LEN_W-1:0] beats_left;
  logic [1:0]       drain_cnt;
  logic             first_pending;
  logic             first_flag;
  logic             first_delayed;

  // Job FSM; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beats_left    <= '0;
      drain_cnt     <= '0;
      first_pending <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state         <= RUN;
              beats_left    <= len;
              first_pending <= 1'b1;
            end else begin
              state <= ZERO;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            first_pending <= 1'b0;
            beats_left    <= beats_left - LEN_ONE;
            if (beats_left == LEN_ONE) begin
              if (DRAIN_LEN == 2'd0) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_LEN;
              end
            end
          end
        end
        ZERO: begin
          if (DRAIN_LEN == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LEN;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (state == RUN);

  // A stalled RUN cycle freezes the whole slice, partial sum included.
  always_comb begin
    dsp_enable = 1'b0;
    op_zero    = 1'b0;
    first_flag = 1'b0;
    case (state)
      RUN: begin
        dsp_enable = in_valid;
        first_flag = first_pending;
      end
      ZERO: begin
        dsp_enable = 1'b1;
        op_zero    = 1'b1;
        first_flag = 1'b1;
      end
      DRAIN: begin
        dsp_enable = 1'b1;
        op_zero    = 1'b1;
      end
      default: ;
    endcase
  end

  ctrl_delay_line #(
    .DEPTH(D),
    .WIDTH(1)
  ) u_first_delay (
    .clk    (clk),
    .rst    (rst),
    .enable (dsp_enable),
    .din    (first_flag),
    .dout   (first_delayed)
  );

  assign dsp_opmode  = first_delayed ? OPM_CLEAR : OPM_ACC;
  assign dsp_inmode  = INMODE_MUL;
  assign dsp_alumode = ALUMODE_ADD;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48E2 slice model.
// Expected per-cycle outputs are planned from job rules before the run.
module tb_dsp_mac_sequencer;
  import dsp_ctrl_pkg::*;

  localparam int LEN_W = 16;
  localparam int LAT   = 3;
  localparam int NCYC  = 88;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [LEN_W-1:0] len;
  logic busy, done, in_ready, op_zero, dsp_enable;
  logic [8:0] dsp_opmode;
  logic [4:0] dsp_inmode;
  logic [3:0] dsp_alumode;
  logic signed [17:0] a_in, b_in;

  dsp_mac_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_zero     (op_zero),
    .dsp_enable  (dsp_enable),
    .dsp_opmode  (dsp_opmode),
    .dsp_inmode  (dsp_inmode),
    .dsp_alumode (dsp_alumode)
  );

  always #5 clk = ~clk;

  // Slice model: A/B, M, OPMODE and P registers, all on the shared CE.
  logic signed [17:0] a_reg, b_reg;
  logic signed [47:0] m_reg, p_reg;
  logic [8:0] opm_reg;

  always @(posedge clk) begin
    if (rst) begin
      a_reg <= '0; b_reg <= '0; m_reg <= '0; p_reg <= '0; opm_reg <= OPM_ACC;
    end else if (dsp_enable) begin
      a_reg   <= a_in;
      b_reg   <= op_zero ? 18'sd0 : b_in;
      m_reg   <= a_reg * b_reg;
      opm_reg <= dsp_opmode;
      p_reg   <= (opm_reg == OPM_CLEAR) ? m_reg : p_reg + m_reg;
    end
  end

  bit     v_rst [NCYC], v_start [NCYC], v_valid [NCYC];
  int     v_len [NCYC], v_a [NCYC], v_b [NCYC];
  bit     e_busy [NCYC], e_done [NCYC], e_ready [NCYC], e_opz [NCYC];
  bit     e_en [NCYC], e_clear [NCYC], e_pchk [NCYC];
  longint e_p [NCYC];
  int     qa [8], qb [8];
  int     cur = 0;
  bit     running = 1'b1;
  int     asserts = 0, fails = 0;
  int     d1, d2, d3a, d3b, d4, d5, d6;
  longint s1, s2, s3a, s3b, s4, s5;

  task automatic checkOutput(input string name, input int cyc, input longint act,
                             input longint exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Fills expectations for one job from its start cycle, length and valid pattern.
  task automatic plan_job(input int s, input int n, output int done_cyc, output longint sum);
    int c, cnt, last, f, g;
    v_start[s] = 1'b1;
    v_len[s]   = n;
    sum = 0; c = s + 1; cnt = 0; f = -1; last = s + 1;
    if (n == 0) begin
      e_busy[c] = 1'b1; e_en[c] = 1'b1; e_opz[c] = 1'b1; f = c;
    end else begin
      while (cnt < n && c < NCYC) begin
        e_busy[c] = 1'b1; e_ready[c] = 1'b1; e_en[c] = v_valid[c];
        if (v_valid[c]) begin
          v_a[c] = qa[cnt]; v_b[c] = qb[cnt];
          sum += longint'(qa[cnt]) * longint'(qb[cnt]);
          if (f < 0) f = c;
          last = c; cnt++;
        end
        c++;
      end
    end
    for (c = last + 1; c < last + LAT; c++) begin
      e_busy[c] = 1'b1; e_en[c] = 1'b1; e_opz[c] = 1'b1;
    end
    done_cyc = last + LAT;
    e_done[done_cyc] = 1'b1; e_pchk[done_cyc] = 1'b1; e_p[done_cyc] = sum;
    g = f + 1;
    while (g < NCYC - 1 && !e_en[g]) g++;
    for (c = f + 1; c <= g; c++) e_clear[c] = 1'b1;
  endtask

  task automatic applyStimulus(input int c);
    rst      = v_rst[c];
    start    = v_start[c];
    len      = LEN_W'(v_len[c]);
    in_valid = v_valid[c];
    a_in     = 18'(v_a[c]);
    b_in     = 18'(v_b[c]);
  endtask

  // Per-cycle compare against the planned expectations.
  always @(negedge clk) begin
    if (running && cur >= 1) begin
      if (cur == 1) begin
        checkOutput("plan_done_job1", cur, d1, 12);
        checkOutput("plan_sum_job1", cur, s1, 70);
        checkOutput("plan_done_stall", cur, d2, 25);
        checkOutput("plan_done_b2b", cur, d3b, 41);
        checkOutput("plan_sum_b2b", cur, s3b, -6);
        checkOutput("plan_done_len0", cur, d4, 49);
        checkOutput("plan_done_ignore", cur, d5, 62);
      end
      checkOutput("busy", cur, busy, e_busy[cur]);
      checkOutput("done", cur, done, e_done[cur]);
      checkOutput("in_ready", cur, in_ready, e_ready[cur]);
      checkOutput("op_zero", cur, op_zero, e_opz[cur]);
      checkOutput("dsp_enable", cur, dsp_enable, e_en[cur]);
      checkOutput("dsp_opmode", cur, dsp_opmode, e_clear[cur] ? OPM_CLEAR : OPM_ACC);
      checkOutput("dsp_inmode", cur, dsp_inmode, 0);
      checkOutput("dsp_alumode", cur, dsp_alumode, 0);
      if (e_pchk[cur]) checkOutput("slice_p", cur, p_reg, e_p[cur]);
    end
  end

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      v_a[c] = 7; v_b[c] = 7;
    end
    v_rst[0] = 1'b1; v_rst[1] = 1'b1; v_rst[2] = 1'b1;
    e_pchk[3] = 1'b1; e_p[3] = 0;

    qa = '{1, 2, 3, 4, 0, 0, 0, 0};
    qb = '{5, 6, 7, 8, 0, 0, 0, 0};
    for (int c = 6; c <= 9; c++) v_valid[c] = 1'b1;
    plan_job(5, 4, d1, s1);

    v_valid[16] = 1'b1;
    for (int c = 20; c <= 22; c++) v_valid[c] = 1'b1;
    plan_job(15, 4, d2, s2);
    for (int c = 17; c <= 19; c++) begin
      e_pchk[c] = 1'b1; e_p[c] = 70;
    end

    for (int c = 31; c <= 34; c++) v_valid[c] = 1'b1;
    plan_job(30, 4, d3a, s3a);
    qa = '{-2, 0, 0, 0, 0, 0, 0, 0};
    qb = '{3, 0, 0, 0, 0, 0, 0, 0};
    v_valid[38] = 1'b1;
    plan_job(d3a, 1, d3b, s3b);

    v_valid[46] = 1'b1;
    plan_job(45, 0, d4, s4);

    qa = '{1, 2, 3, 4, 0, 0, 0, 0};
    qb = '{5, 6, 7, 8, 0, 0, 0, 0};
    for (int c = 56; c <= 59; c++) v_valid[c] = 1'b1;
    plan_job(55, 4, d5, s5);
    v_start[57] = 1'b1; v_len[57] = 2;

    qa = '{1, 2, 3, 4, 5, 6, 7, 8};
    qb = '{1, 1, 1, 1, 1, 1, 1, 1};
    for (int c = 71; c <= 78; c++) v_valid[c] = 1'b1;
    plan_job(70, 8, d6, s4);
    v_rst[73] = 1'b1;
    // Reset aborts the job: everything from the next cycle on is idle.
    for (int c = 74; c < NCYC; c++) begin
      e_busy[c] = 1'b0; e_done[c] = 1'b0; e_ready[c] = 1'b0; e_opz[c] = 1'b0;
      e_en[c] = 1'b0; e_clear[c] = 1'b0; e_pchk[c] = 1'b0;
    end
    e_pchk[74] = 1'b1; e_p[74] = 0;

    applyStimulus(0);
    for (int c = 1; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cur = c;
      applyStimulus(c);
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
